// File: rtl/cpu_controller.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cpu_controller: eight-state instruction-cycle sequencer for the 8-bit |
// | accumulator CPU. Optional single-step port: CTRL_SINGLE_STEP_EN.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cpu_controller #(
  parameter int HALT_STICKY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       load_ir,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       alu_ena,
  output logic       load_acc,
  output logic       halt
);

  localparam logic [2:0] c_OP_HLT = 3'b000;
  localparam logic [2:0] c_OP_SKZ = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_AND = 3'b011;
  localparam logic [2:0] c_OP_XOR = 3'b100;
  localparam logic [2:0] c_OP_LDA = 3'b101;
  localparam logic [2:0] c_OP_STO = 3'b110;
  localparam logic [2:0] c_OP_JMP = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_S0   = 4'd1,
    ST_S1   = 4'd2,
    ST_S2   = 4'd3,
    ST_S3   = 4'd4,
    ST_S4   = 4'd5,
    ST_S5   = 4'd6,
    ST_S6   = 4'd7,
    ST_S7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  state_t r_state;
  logic   r_ena_q;
  logic   w_go;
  logic   w_alu_op;
  logic   w_skip;

`ifdef CTRL_SINGLE_STEP_EN
  assign w_go = ena & step;
`else
  assign w_go = ena;
`endif

  assign w_alu_op = (opcode == c_OP_ADD) || (opcode == c_OP_AND) ||
                    (opcode == c_OP_XOR) || (opcode == c_OP_LDA);
  assign w_skip   = (opcode == c_OP_SKZ) && zero;

  // Each branch sets the outputs belonging to the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ena_q     <= 1'b0;
      load_ir     <= 1'b0;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      datactl_ena <= 1'b0;
      alu_ena     <= 1'b0;
      load_acc    <= 1'b0;
      halt        <= 1'b0;
    end else begin
      r_ena_q     <= ena;
      load_ir     <= 1'b0;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      datactl_ena <= 1'b0;
      alu_ena     <= 1'b0;
      load_acc    <= 1'b0;
      halt        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_state <= ST_S0;
            rd      <= 1'b1;
            load_ir <= 1'b1;
          end
        end
        ST_S0: begin
          r_state <= ST_S1;
          rd      <= 1'b1;
          load_ir <= 1'b1;
          inc_pc  <= 1'b1;
        end
        ST_S1: r_state <= ST_S2;
        ST_S2: begin
          r_state <= ST_S3;
          inc_pc  <= 1'b1;
          halt    <= (opcode == c_OP_HLT);
        end
        ST_S3: begin
          if (opcode == c_OP_HLT) begin
            r_state <= ST_HALT;
            halt    <= 1'b1;
          end else begin
            r_state <= ST_S4;
            if (w_alu_op) begin
              rd      <= 1'b1;
              alu_ena <= 1'b1;
            end
            if (opcode == c_OP_STO) datactl_ena <= 1'b1;
            if (opcode == c_OP_JMP) load_pc     <= 1'b1;
          end
        end
        ST_S4: begin
          r_state <= ST_S5;
          if (w_alu_op) begin
            rd       <= 1'b1;
            load_acc <= 1'b1;
          end
          if (opcode == c_OP_STO) begin
            wr          <= 1'b1;
            datactl_ena <= 1'b1;
          end
          if (opcode == c_OP_JMP) load_pc <= 1'b1;
          if (w_skip)             inc_pc  <= 1'b1;
        end
        ST_S5: begin
          r_state <= ST_S6;
          if (w_alu_op)           rd          <= 1'b1;
          if (opcode == c_OP_STO) datactl_ena <= 1'b1;
        end
        ST_S6: begin
          r_state <= ST_S7;
          if (w_skip) inc_pc <= 1'b1;
        end
        ST_S7: begin
          if (w_go) begin
            r_state <= ST_S0;
            rd      <= 1'b1;
            load_ir <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          // Non-sticky builds resume only on a fresh rising edge of ena.
          if ((HALT_STICKY == 0) && ena && !r_ena_q) begin
            r_state <= ST_S0;
            rd      <= 1'b1;
            load_ir <= 1'b1;
          end else begin
            halt <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
